id_exe_stage_reg: RTL

// - ID->EXE pipeline register of the ARM 5-stage core; consumes hazard from the hazard detection unit.
// - On load-use hazard, inserts a bubble (NOP) into EXE while IF/ID hold upstream.
// - Registered exe_dest/exe_mem_r_en feed back to the hazard unit next cycle.
// - Flush on taken branch; freeze on global stall; saturating bubble/flush counters for perf debug.

---
 rtl/arm_pipe_pkg.sv | 31 +++
 rtl/id_exe_stage_reg_sat_counter.sv | 26 ++
 rtl/id_exe_stage_reg.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/arm_pipe_pkg.sv
// Shared ARM pipeline definitions: field widths, the NOP command and the
// packed control bundle carried from ID to EXE.
package arm_pipe_pkg;

    localparam int EXE_CMD_W  = 4;
    localparam int SHIFT_OP_W = 12;
    localparam int SIMM24_W   = 24;
    localparam int REG_IDX_W  = 4;

    localparam logic [EXE_CMD_W-1:0] EXE_CMD_NOP = '0;

    typedef struct packed {
        logic                 wb_en;
        logic                 mem_r_en;
        logic                 mem_w_en;
        logic                 b;
        logic                 s;
        logic [EXE_CMD_W-1:0] exe_cmd;
    } id_ctrl_t;

    // A bubble must not write state nor look like a load to the hazard unit.
    localparam id_ctrl_t ID_CTRL_NOP = '{
        wb_en:    1'b0,
        mem_r_en: 1'b0,
        mem_w_en: 1'b0,
        b:        1'b0,
        s:        1'b0,
        exe_cmd:  EXE_CMD_NOP
    };

endpackage

// File: rtl/id_exe_stage_reg_sat_counter.sv
// Saturating up-counter used for pipeline bubble/flush statistics.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;
    logic         w_sat;

    assign w_sat = &r_count;
    assign count = r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (en && !w_sat) begin
            r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/id_exe_stage_reg.sv
// ID->EXE pipeline register of the ARM 5-stage core with freeze, flush and
// load-use bubble insertion, plus saturating bubble/flush statistics.
module id_exe_stage_reg
    import arm_pipe_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic                  hazard,
    input  logic [WORD_W-1:0]     id_pc,
    input  logic [WORD_W-1:0]     id_val_rn,
    input  logic [WORD_W-1:0]     id_val_rm,
    input  logic                  id_imm,
    input  logic [SHIFT_OP_W-1:0] id_shift_op,
    input  logic [SIMM24_W-1:0]   id_simm24,
    input  logic [REG_IDX_W-1:0]  id_dest,
    input  logic [REG_IDX_W-1:0]  id_src1,
    input  logic [REG_IDX_W-1:0]  id_src2,
    input  logic [EXE_CMD_W-1:0]  id_exe_cmd,
    input  logic                  id_wb_en,
    input  logic                  id_mem_r_en,
    input  logic                  id_mem_w_en,
    input  logic                  id_b,
    input  logic                  id_s,
    input  logic                  id_c_in,
    output logic [WORD_W-1:0]     ex_pc,
    output logic [WORD_W-1:0]     ex_val_rn,
    output logic [WORD_W-1:0]     ex_val_rm,
    output logic                  ex_imm,
    output logic [SHIFT_OP_W-1:0] ex_shift_op,
    output logic [SIMM24_W-1:0]   ex_simm24,
    output logic [REG_IDX_W-1:0]  ex_dest,
    output logic [REG_IDX_W-1:0]  ex_src1,
    output logic [REG_IDX_W-1:0]  ex_src2,
    output logic [EXE_CMD_W-1:0]  ex_exe_cmd,
    output logic                  ex_wb_en,
    output logic                  ex_mem_r_en,
    output logic                  ex_mem_w_en,
    output logic                  ex_b,
    output logic                  ex_s,
    output logic                  ex_c_in,
    output logic                  ex_valid,
    output logic [CNT_W-1:0]      bubble_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    logic [WORD_W-1:0]     r_pc;
    logic [WORD_W-1:0]     r_val_rn;
    logic [WORD_W-1:0]     r_val_rm;
    logic                  r_imm;
    logic [SHIFT_OP_W-1:0] r_shift_op;
    logic [SIMM24_W-1:0]   r_simm24;
    logic [REG_IDX_W-1:0]  r_dest;
    logic [REG_IDX_W-1:0]  r_src1;
    logic [REG_IDX_W-1:0]  r_src2;
    logic                  r_c_in;
    logic                  r_valid;
    id_ctrl_t              r_ctrl;

    id_ctrl_t w_id_ctrl;
    logic     w_clear;
    logic     w_flush_en;
    logic     w_bubble_en;

    assign w_id_ctrl = '{
        wb_en:    id_wb_en,
        mem_r_en: id_mem_r_en,
        mem_w_en: id_mem_w_en,
        b:        id_b,
        s:        id_s,
        exe_cmd:  id_exe_cmd
    };

    // Flush outranks hazard, so a cycle with both is counted only as a flush.
    assign w_clear     = flush | hazard;
    assign w_flush_en  = ~freeze & flush;
    assign w_bubble_en = ~freeze & ~flush & hazard;

    // ID -> EXE stage boundary
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc       <= '0;
            r_val_rn   <= '0;
            r_val_rm   <= '0;
            r_imm      <= 1'b0;
            r_shift_op <= '0;
            r_simm24   <= '0;
            r_dest     <= '0;
            r_src1     <= '0;
            r_src2     <= '0;
            r_c_in     <= 1'b0;
            r_ctrl     <= ID_CTRL_NOP;
            r_valid    <= 1'b0;
        end else if (!freeze) begin
            if (w_clear) begin
                r_pc       <= '0;
                r_val_rn   <= '0;
                r_val_rm   <= '0;
                r_imm      <= 1'b0;
                r_shift_op <= '0;
                r_simm24   <= '0;
                r_dest     <= '0;
                r_src1     <= '0;
                r_src2     <= '0;
                r_c_in     <= 1'b0;
                r_ctrl     <= ID_CTRL_NOP;
                r_valid    <= 1'b0;
            end else begin
                r_pc       <= id_pc;
                r_val_rn   <= id_val_rn;
                r_val_rm   <= id_val_rm;
                r_imm      <= id_imm;
                r_shift_op <= id_shift_op;
                r_simm24   <= id_simm24;
                r_dest     <= id_dest;
                r_src1     <= id_src1;
                r_src2     <= id_src2;
                r_c_in     <= id_c_in;
                r_ctrl     <= w_id_ctrl;
                r_valid    <= 1'b1;
            end
        end
    end

    assign ex_pc       = r_pc;
    assign ex_val_rn   = r_val_rn;
    assign ex_val_rm   = r_val_rm;
    assign ex_imm      = r_imm;
    assign ex_shift_op = r_shift_op;
    assign ex_simm24   = r_simm24;
    assign ex_dest     = r_dest;
    assign ex_src1     = r_src1;
    assign ex_src2     = r_src2;
    assign ex_c_in     = r_c_in;
    assign ex_wb_en    = r_ctrl.wb_en;
    assign ex_mem_r_en = r_ctrl.mem_r_en;
    assign ex_mem_w_en = r_ctrl.mem_w_en;
    assign ex_b        = r_ctrl.b;
    assign ex_s        = r_ctrl.s;
    assign ex_exe_cmd  = r_ctrl.exe_cmd;
    assign ex_valid    = r_valid;

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (w_bubble_en),
        .count (bubble_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (w_flush_en),
        .count (flush_cnt)
    );

endmodule
